col_merge: RTL and testbench
============================

Name: col_merge

Overview:
- Read-side counterpart of the partition block.
- Drains the COL_MAX_SIZE per-column info/data FIFO pairs that partition fills.
- Visits columns round-robin, one segment at a time, and writes each segment into the back FIFO for feedback to return over C2H.
- Signals process_done and data_len to feedback once partition_done has been seen and every column is drained.

Parameters:
TCQ, 1, simulation clock-to-Q delay on registered assignments
DATA_WIDTH, 128, width of FIFO words in bits
COL_MAX_SIZE, 4, number of column FIFO pairs
BYTE_BIT_ENABLE, DATA_WIDTH/8, bytes per word (data_len scaling)

Ports:
user_clk  in  1  clock
user_rst  in  1  asynchronous active-low reset
info_rd_en  out  COL_MAX_SIZE  per-column info FIFO read strobe
info_dout  in  COL_MAX_SIZE*DATA_WIDTH  concatenated info FIFO outputs, column i at [i*DATA_WIDTH +: DATA_WIDTH]
info_empty  in  COL_MAX_SIZE  info FIFO empty flags
data_rd_en  out  COL_MAX_SIZE  per-column data FIFO read strobe
data_dout  in  COL_MAX_SIZE*DATA_WIDTH  concatenated data FIFO outputs
data_empty  in  COL_MAX_SIZE  data FIFO empty flags
partition_done  in  1  one-cycle pulse: partition finished writing the current job
fifo_din  out  DATA_WIDTH  back FIFO write data
fifo_wr_en  out  1  back FIFO write strobe
fifo_full  in  1  back FIFO full
process_done  out  1  one-cycle pulse: job fully merged
data_len  out  32  bytes written to back FIFO for the job

Behaviour:
- FIFO model: all column FIFOs are standard mode. dout is valid the cycle after rd_en. Never assert rd_en on an empty FIFO. Never assert fifo_wr_en while fifo_full=1.
- Reset: all outputs 0. FSM in IDLE, rr_ptr=0, done_pending=0, skid buffer empty, beat counter 0. Reset mid-segment abandons the segment; column FIFOs are flushed separately by their own srst.
- Info word format: bits [31:0] = segment length N in data words; bits above 31 are ignored. N=0 is legal.
- FSM states:
  - IDLE: scan columns starting at rr_ptr for the first with info_empty=0. If found, latch col, pulse info_rd_en[col] for 1 cycle, go INFO_LAT. If none is found and done_pending=1, go DONE.
  - INFO_LAT: capture info_dout[col], load remaining=N. If the header feature is on, go HDR; else go DATA, or go NEXT if N=0.
  - HDR: push the info word into the skid buffer, then go DATA, or NEXT if N=0.
  - DATA: issue data_rd_en[col] when data_empty[col]=0, remaining>0 and (skid occupancy + reads in flight) < 2. Decrement remaining per issue. When remaining=0 and no read is in flight, go NEXT. Data FIFO empty mid-segment means stall indefinitely, with no timeout.
  - NEXT: rr_ptr = col+1 mod COL_MAX_SIZE, go IDLE.
  - DONE: pulse process_done for 1 cycle, clear done_pending, go IDLE.
- DONE waits until the skid buffer has drained, so all words are in the back FIFO before process_done.
- Skid: 2-entry buffer between read returns and the back FIFO. Head is written (fifo_wr_en=1) whenever non-empty and fifo_full=0. Sustained throughput is 1 word/cycle. Latency from data_rd_en to fifo_wr_en is 2 cycles when not full.
- done_pending: set by partition_done in any state, including mid-segment. partition_done arriving in the same cycle as the DONE pulse re-arms done_pending for the next job.
- data_len: beat_count*BYTE_BIT_ENABLE. beat_count increments on each fifo_wr_en and saturates at 0xFFFFFFFF bytes. data_len holds stable after process_done. beat_count clears on the first info pop of the next job.
- Fairness: exactly one segment per column per visit. A column with a pending info word is visited within COL_MAX_SIZE segments.

Optional Feature:
COL_MERGE_HDR_EN:
- Defined: each segment is preceded in the back FIFO by its info word (header), and the header counts in data_len.
- Undefined: HDR state is removed; only data words are forwarded and counted.

Decomposition:
- Package col_merge_pkg holds:
  - FSM state enum (IDLE, INFO_LAT, HDR, DATA, NEXT, DONE)
  - SEG_LEN_LSB=0, SEG_LEN_MSB=31
  - function for round-robin next-non-empty search
- Sub-module col_merge_skid: 2-entry skid FIFO with occupancy output, parameterised on DATA_WIDTH.

Test Plan:
- Col0 info N=3, data A,B,C; then partition_done -> back FIFO receives A,B,C (plus header if HDR_EN); process_done pulses once; data_len=48 (64 with HDR_EN).
- Col1 N=2 and col3 N=1 loaded simultaneously, rr_ptr=0 -> order col1 then col3; data_len=48 without HDR_EN.
- Col2 N=0 info only -> no data read; header only if HDR_EN; rr_ptr advances to 3; no hang.
- fifo_full held 1 for 10 cycles mid-segment of N=8 -> no write while full, no overflow; all 8 words arrive in order; no more than 2 reads outstanding.
- partition_done pulsed during DATA of col0 N=4 with col2 info pending -> col0 completes, col2 drained, then exactly one process_done.
- Assert user_rst low mid-DATA -> all outputs 0 asynchronously; after release FSM is IDLE and rr_ptr=0.

Source files
------------

// File: rtl/col_merge_pkg.sv
// Shared types and helpers for col_merge: FSM state encoding, segment-length
// field position in the info word, and the round-robin column search.
package col_merge_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INFO_LAT = 3'd1,
    S_HDR      = 3'd2,
    S_DATA     = 3'd3,
    S_NEXT     = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  localparam int SEG_LEN_LSB = 0;
  localparam int SEG_LEN_MSB = 31;

  // Column indices are carried as 5 bits, so up to 32 columns are supported.
  localparam int RR_MAX = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // First set bit of avail at or after ptr, wrapping within ncol columns.
  function automatic rr_pick_t rr_search(input logic [RR_MAX-1:0] avail,
                                         input logic [4:0]        ptr,
                                         input logic [5:0]        ncol);
    rr_pick_t   pick;
    logic [5:0] idx;
    pick = '0;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + 6'(i);
      if (idx >= ncol) begin
        idx = idx - ncol;
      end
      if ((6'(i) < ncol) && avail[idx[4:0]]) begin
        pick.found = 1'b1;
        pick.idx   = idx[4:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/col_merge_skid.sv
// Two-entry skid FIFO between column read returns and the back FIFO.
// Head is visible combinationally; occ reports stored entries.
module col_merge_skid
  import col_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem0_q, mem0_d;
  logic [DATA_WIDTH-1:0] mem1_q, mem1_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  do_pop_s, do_push_s;

  // A push into a full buffer is legal only alongside a pop of the same slot.
  always_comb begin
    mem0_d    = mem0_q;
    mem1_d    = mem1_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    do_pop_s  = pop && (occ_q != 2'd0);
    do_push_s = push && ((occ_q != 2'd2) || do_pop_s);
    if (do_push_s) begin
      if (wr_ptr_q) begin
        mem1_d = push_data;
      end else begin
        mem0_d = push_data;
      end
      wr_ptr_d = ~wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head = rd_ptr_q ? mem1_q : mem0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/col_merge.sv
// Drains per-column info/data FIFO pairs round-robin into the back FIFO.
// Define COL_MERGE_HDR_EN to forward each info word as a segment header.
module col_merge
  import col_merge_pkg::*;
#(
  parameter int TCQ             = 1,
  parameter int DATA_WIDTH      = 128,
  parameter int COL_MAX_SIZE    = 4,
  parameter int BYTE_BIT_ENABLE = DATA_WIDTH / 8
) (
  input  logic                               user_clk,
  input  logic                               user_rst,
  output logic [COL_MAX_SIZE-1:0]            info_rd_en,
  input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0] info_dout,
  input  logic [COL_MAX_SIZE-1:0]            info_empty,
  output logic [COL_MAX_SIZE-1:0]            data_rd_en,
  input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0] data_dout,
  input  logic [COL_MAX_SIZE-1:0]            data_empty,
  input  logic                               partition_done,
  output logic [DATA_WIDTH-1:0]              fifo_din,
  output logic                               fifo_wr_en,
  input  logic                               fifo_full,
  output logic                               process_done,
  output logic [31:0]                        data_len
);

  localparam int LEN_W = SEG_LEN_MSB - SEG_LEN_LSB + 1;

  // TCQ only matters to behavioural models; the synthesizable flops ignore it.
  if (TCQ < 0) begin : g_tcq_range
  end

  state_e              state_q, state_d;
  logic [4:0]          col_q, col_d;
  logic [4:0]          rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic                done_pending_q, done_pending_d;
  logic                inflight_q, inflight_d;
  logic                new_job_q, new_job_d;
  logic [31:0]         bytes_q, bytes_d;
`ifdef COL_MERGE_HDR_EN
  logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
`endif

  logic [RR_MAX-1:0]     avail_s;
  rr_pick_t              pick_s;
  logic [LEN_W-1:0]      seg_len_s;
  logic                  info_pop_s, issue_s, hdr_push_s, wr_s, empty_sel_s;
  logic                  skid_push_s;
  logic [DATA_WIDTH-1:0] skid_din_s, skid_head_s;
  logic [1:0]            occ_s, room_s;
  logic [32:0]           bytes_sum_s;
  logic [31:0]           bytes_base_s;

  col_merge_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (user_clk),
    .rst_n     (user_rst),
    .push      (skid_push_s),
    .push_data (skid_din_s),
    .pop       (wr_s),
    .head      (skid_head_s),
    .occ       (occ_s)
  );

  // Column selection, read strobes and skid admission.
  always_comb begin
    avail_s                   = '0;
    avail_s[COL_MAX_SIZE-1:0] = ~info_empty;
    pick_s      = rr_search(avail_s, rr_ptr_q, 6'(COL_MAX_SIZE));
    seg_len_s   = info_dout[col_q*DATA_WIDTH + SEG_LEN_LSB +: LEN_W];
    empty_sel_s = 1'b1;
    for (int i = 0; i < COL_MAX_SIZE; i++) begin
      if (col_q == 5'(i)) begin
        empty_sel_s = data_empty[i];
      end
    end
    wr_s   = (occ_s != 2'd0) && !fifo_full;
    // Entries still owed to the skid after this cycle's write leaves.
    room_s = occ_s - {1'b0, wr_s} + {1'b0, inflight_q};
    info_pop_s = user_rst && (state_q == S_IDLE) && pick_s.found;
    issue_s    = (state_q == S_DATA) && (remaining_q != '0) && !empty_sel_s
                 && (room_s < 2'd2);
    for (int i = 0; i < COL_MAX_SIZE; i++) begin
      info_rd_en[i] = info_pop_s && (pick_s.idx == 5'(i));
      data_rd_en[i] = issue_s && (col_q == 5'(i));
    end
  end

  // Segment sequencing FSM.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    rr_ptr_d    = rr_ptr_q;
    remaining_d = remaining_q;
    hdr_push_s  = 1'b0;
`ifdef COL_MERGE_HDR_EN
    hdr_d       = hdr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_s.found) begin
          col_d   = pick_s.idx;
          state_d = S_INFO_LAT;
        end else if (done_pending_q && (occ_s == 2'd0) && !inflight_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INFO_LAT: begin
        remaining_d = seg_len_s;
`ifdef COL_MERGE_HDR_EN
        hdr_d   = info_dout[col_q*DATA_WIDTH +: DATA_WIDTH];
        state_d = S_HDR;
`else
        state_d = (seg_len_s == '0) ? S_NEXT : S_DATA;
`endif
      end
      S_HDR: begin
`ifdef COL_MERGE_HDR_EN
        if (room_s < 2'd2) begin
          hdr_push_s = 1'b1;
          state_d    = (remaining_q == '0) ? S_NEXT : S_DATA;
        end else begin
          state_d = S_HDR;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DATA: begin
        if (issue_s) begin
          remaining_d = remaining_q - 1'b1;
        end
        if ((remaining_q == '0) && !inflight_q) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_DATA;
        end
      end
      S_NEXT: begin
        rr_ptr_d = (col_q == 5'(COL_MAX_SIZE - 1)) ? 5'd0 : col_q + 5'd1;
        state_d  = S_IDLE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Skid feed, job bookkeeping and saturating byte count.
  always_comb begin
    skid_push_s = inflight_q || hdr_push_s;
`ifdef COL_MERGE_HDR_EN
    skid_din_s  = hdr_push_s ? hdr_q : data_dout[col_q*DATA_WIDTH +: DATA_WIDTH];
`else
    skid_din_s  = data_dout[col_q*DATA_WIDTH +: DATA_WIDTH];
`endif
    inflight_d     = issue_s;
    done_pending_d = partition_done || (done_pending_q && (state_q != S_DONE));
    if (state_q == S_DONE) begin
      new_job_d = 1'b1;
    end else if (info_pop_s) begin
      new_job_d = 1'b0;
    end else begin
      new_job_d = new_job_q;
    end
    bytes_base_s = (info_pop_s && new_job_q) ? 32'd0 : bytes_q;
    bytes_sum_s  = {1'b0, bytes_base_s} + 33'(BYTE_BIT_ENABLE);
    if (wr_s) begin
      bytes_d = bytes_sum_s[32] ? 32'hFFFF_FFFF : bytes_sum_s[31:0];
    end else begin
      bytes_d = bytes_base_s;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst) begin
    if (!user_rst) begin
      state_q        <= S_IDLE;
      col_q          <= 5'd0;
      rr_ptr_q       <= 5'd0;
      remaining_q    <= '0;
      done_pending_q <= 1'b0;
      inflight_q     <= 1'b0;
      new_job_q      <= 1'b1;
      bytes_q        <= 32'd0;
`ifdef COL_MERGE_HDR_EN
      hdr_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      rr_ptr_q       <= rr_ptr_d;
      remaining_q    <= remaining_d;
      done_pending_q <= done_pending_d;
      inflight_q     <= inflight_d;
      new_job_q      <= new_job_d;
      bytes_q        <= bytes_d;
`ifdef COL_MERGE_HDR_EN
      hdr_q          <= hdr_d;
`endif
    end
  end

  assign fifo_din     = skid_head_s;
  assign fifo_wr_en   = wr_s;
  assign process_done = (state_q == S_DONE);
  assign data_len     = bytes_q;

endmodule

// File: tb/tb_col_merge.sv
// Directed self-checking bench for col_merge with behavioural standard-mode
// column FIFOs and an in-order expectation queue for the back FIFO.
`timescale 1ns/1ps
module tb_col_merge;

  localparam int DW  = 128;
  localparam int NC  = 4;
  localparam int BBE = DW / 8;
`ifdef COL_MERGE_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   info_rd_en, info_empty, data_rd_en, data_empty;
  logic [NC*DW-1:0] info_dout, data_dout;
  logic            partition_done, fifo_full, fifo_wr_en, process_done;
  logic [DW-1:0]   fifo_din;
  logic [31:0]     data_len;

  logic [DW-1:0] imem [NC][16];
  logic [DW-1:0] dmem [NC][16];
  int            ihd [NC];
  int            itl [NC];
  int            dhd [NC];
  int            dtl [NC];
  logic [DW-1:0] exp_q [$];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            done_cnt = 0;
  int            os       = 0;

  always #5 clk = ~clk;

  col_merge #(.TCQ(1), .DATA_WIDTH(DW), .COL_MAX_SIZE(NC), .BYTE_BIT_ENABLE(BBE)) dut (
    .user_clk       (clk),
    .user_rst       (rst_n),
    .info_rd_en     (info_rd_en),
    .info_dout      (info_dout),
    .info_empty     (info_empty),
    .data_rd_en     (data_rd_en),
    .data_dout      (data_dout),
    .data_empty     (data_empty),
    .partition_done (partition_done),
    .fifo_din       (fifo_din),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_full      (fifo_full),
    .process_done   (process_done),
    .data_len       (data_len)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] info_w(input int c, input int n);
    return {32'hC0DE_0000 + 32'(c), 32'h1234_5678, 32'hFFFF_FFFF, 32'(n)};
  endfunction

  function automatic logic [DW-1:0] data_w(input int c, input int i);
    return {32'hDA7A_0000 + 32'(c), 32'(i) ^ 32'h5A5A_5A5A, 32'hCAFE_0000 + 32'(i), 32'(c * 16 + i)};
  endfunction

  task automatic update_flags();
    for (int i = 0; i < NC; i++) begin
      info_empty[i] = (ihd[i] == itl[i]);
      data_empty[i] = (dhd[i] == dtl[i]);
    end
  endtask

  task automatic push_info(input int c, input int n);
    imem[c][itl[c] % 16] = info_w(c, n);
    itl[c]++;
    update_flags();
  endtask

  task automatic push_data(input int c, input int i);
    dmem[c][dtl[c] % 16] = data_w(c, i);
    dtl[c]++;
    update_flags();
  endtask

  task automatic exp_hdr(input int c, input int n);
`ifdef COL_MERGE_HDR_EN
    exp_q.push_back(info_w(c, n));
`else
    if (c < 0 || n < 0) exp_q.push_back('0);
`endif
  endtask

  task automatic exp_data(input int c, input int i);
    exp_q.push_back(data_w(c, i));
  endtask

  // One clock: sample at negedge, model FIFO pops/returns after posedge.
  task automatic tick();
    logic [DW-1:0] ipop [NC];
    logic [DW-1:0] dpop [NC];
    logic [NC-1:0] ihit, dhit;
    ihit = '0;
    dhit = '0;
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      ipop[i] = '0;
      dpop[i] = '0;
      if (info_rd_en[i]) begin
        check("info_rd_nonempty", (itl[i] != ihd[i]), 1);
        if (itl[i] != ihd[i]) begin
          ipop[i] = imem[i][ihd[i] % 16];
          ihd[i]++;
          ihit[i] = 1'b1;
        end
      end
      if (data_rd_en[i]) begin
        check("data_rd_nonempty", (dtl[i] != dhd[i]), 1);
        os++;
        if (dtl[i] != dhd[i]) begin
          dpop[i] = dmem[i][dhd[i] % 16];
          dhd[i]++;
          dhit[i] = 1'b1;
        end
      end
    end
    if (fifo_wr_en) begin
      check("wr_while_full", fifo_full, 0);
      check("write_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("back_fifo_word", fifo_din, exp_q.pop_front());
`ifndef COL_MERGE_HDR_EN
      os--;
`endif
    end
`ifndef COL_MERGE_HDR_EN
    if (|data_rd_en) check("outstanding_le2", (os <= 2), 1);
`endif
    if (process_done) done_cnt++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (ihit[i]) info_dout[i*DW +: DW] = ipop[i];
      if (dhit[i]) data_dout[i*DW +: DW] = dpop[i];
    end
    update_flags();
  endtask

  task automatic pulse_done();
    partition_done = 1'b1;
    tick();
    partition_done = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done_cnt - start, 1);
    repeat (8) tick();
    check({tag, "_done_once"}, done_cnt - start, 1);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_info_rd_en"}, info_rd_en, 0);
    check({tag, "_data_rd_en"}, data_rd_en, 0);
    check({tag, "_fifo_wr_en"}, fifo_wr_en, 0);
    check({tag, "_fifo_din"}, fifo_din, 0);
    check({tag, "_process_done"}, process_done, 0);
    check({tag, "_data_len"}, data_len, 0);
  endtask

  initial begin
    int sz;
    rst_n = 1'b0;
    partition_done = 1'b0;
    fifo_full = 1'b0;
    info_dout = '0;
    data_dout = '0;
    for (int i = 0; i < NC; i++) begin
      ihd[i] = 0; itl[i] = 0; dhd[i] = 0; dtl[i] = 0;
    end
    update_flags();
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single segment on col0.
    push_info(0, 3);
    exp_hdr(0, 3);
    for (int i = 0; i < 3; i++) begin
      push_data(0, i);
      exp_data(0, i);
    end
    pulse_done();
    wait_done("t1", 100);
    check("t1_len", data_len, 48 + 16 * HDR);
    repeat (5) tick();
    check("t1_len_hold", data_len, 48 + 16 * HDR);

    // col1 and col3 pending together; rr_ptr is 1 so col1 goes first.
    push_info(1, 2);
    push_info(3, 1);
    push_data(1, 0); push_data(1, 1); push_data(3, 0);
    exp_hdr(1, 2); exp_data(1, 0); exp_data(1, 1);
    exp_hdr(3, 1); exp_data(3, 0);
    pulse_done();
    wait_done("t2", 100);
    check("t2_len", data_len, 48 + 32 * HDR);

    // Zero-length segment on col2 must not touch its data FIFO.
    push_info(2, 0);
    push_data(2, 9);
    exp_hdr(2, 0);
    pulse_done();
    wait_done("t3", 100);
    check("t3_len", data_len, 16 * HDR);
    check("t3_no_data_read", dtl[2] - dhd[2], 1);
    dhd[2] = dtl[2];
    update_flags();
    // rr_ptr now 3: col3 ahead of col0.
    push_info(0, 1); push_info(3, 1);
    push_data(0, 5); push_data(3, 5);
    exp_hdr(3, 1); exp_data(3, 5);
    exp_hdr(0, 1); exp_data(0, 5);
    pulse_done();
    wait_done("t3rr", 100);
    check("t3rr_len", data_len, 32 + 32 * HDR);

    // Back-pressure mid-segment on col1, N=8.
    push_info(1, 8);
    exp_hdr(1, 8);
    for (int i = 0; i < 8; i++) begin
      push_data(1, i);
      exp_data(1, i);
    end
    repeat (5) tick();
    fifo_full = 1'b1;
    sz = exp_q.size();
    repeat (10) tick();
    check("t4_no_write_full", exp_q.size(), sz);
    fifo_full = 1'b0;
    pulse_done();
    wait_done("t4", 200);
    check("t4_len", data_len, 128 + 16 * HDR);

    // partition_done during col0 DATA while col2 info is pending.
    push_info(0, 4);
    push_data(0, 0); push_data(0, 1);
    exp_hdr(0, 4);
    for (int i = 0; i < 4; i++) exp_data(0, i);
    exp_hdr(2, 2); exp_data(2, 0); exp_data(2, 1);
    repeat (6) tick();
    push_info(2, 2);
    push_data(2, 0); push_data(2, 1);
    pulse_done();
    repeat (3) tick();
    check("t5_no_early_done", done_cnt, 5);
    push_data(0, 2); push_data(0, 3);
    wait_done("t5", 200);
    check("t5_len", data_len, 96 + 32 * HDR);

    // Asynchronous reset while col3 is stalled mid-segment.
    push_info(3, 4);
    push_data(3, 0); push_data(3, 1);
    exp_hdr(3, 4); exp_data(3, 0); exp_data(3, 1);
    repeat (8) tick();
    check("t6_prereset_len", data_len, 32 + 16 * HDR);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    for (int i = 0; i < NC; i++) begin
      ihd[i] = itl[i];
      dhd[i] = dtl[i];
    end
    exp_q.delete();
    os = 0;
    update_flags();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    // rr_ptr back at 0: col0 ahead of col3.
    push_info(0, 1); push_info(3, 1);
    push_data(0, 7); push_data(3, 7);
    exp_hdr(0, 1); exp_data(0, 7);
    exp_hdr(3, 1); exp_data(3, 7);
    pulse_done();
    wait_done("t6", 100);
    check("t6_len", data_len, 32 + 32 * HDR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
